// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, FSM states, ALU ops and decode helpers for the multicycle core
package mips_pkg;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return op == OP_R ? fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT}
                          : op inside {OP_J, OP_BEQ, OP_ADDIU, OP_LW, OP_SW};
    endfunction
    function automatic alu_op_t alu_op_of(input logic [5:0] op, input logic [5:0] fn);
        return op != OP_R ? ALU_ADD : fn == FN_SUBU ? ALU_SUB : fn == FN_AND ? ALU_AND :
               fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : ALU_ADD;
    endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async reads, one sync write, $0 reads as zero
module mips_regfile #(
    parameter bit CLR_REGS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [32];
    assign rd1 = ra1 == 5'd0 ? 32'd0 : regs[ra1];
    assign rd2 = ra2 == 5'd0 ? 32'd0 : regs[ra2];
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLR_REGS) for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) regs[wa] <= wd;
    end
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-I subset core with a shared req/ready memory port and a trap state
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16,
    parameter bit          CLR_REGS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] pc_out,
    output logic        halted
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    state_t state, state_n;
    alu_op_t alu_op;
    logic [31:0] pc, ir, a, b, alu_out, mdr, imm, src, alu_res, rd1, rd2;
    logic [WW-1:0] wait_cnt;
    logic [5:0] op;
    logic retire_q, done, xfer, timeout;
    assign op = ir[31:26];
    assign imm = {{16{ir[15]}}, ir[15:0]};
    assign src = op == OP_R ? b : imm;
    assign alu_op = alu_op_of(op, ir[5:0]);
    assign alu_res = alu_op == ALU_SUB ? a - src : alu_op == ALU_AND ? a & src : alu_op == ALU_OR ? a | src :
                     alu_op == ALU_SLT ? {31'd0, $signed(a) < $signed(src)} : a + src;
    assign mem_req = !reset && (state == S_FETCH || state == S_MEM);
    assign mem_we = mem_req && state == S_MEM && op == OP_SW;
    assign mem_addr = !reset && state == S_MEM ? alu_out : pc;
    assign mem_wdata = b;
    assign retire = retire_q && !reset;
    assign halted = !reset && state == S_TRAP;
    assign xfer = mem_req && mem_ready;
    assign timeout = mem_req && !mem_ready && wait_cnt == WW'(MAX_WAIT - 1);
    mips_regfile #(.CLR_REGS(CLR_REGS)) u_rf (
        .clk(clk), .reset(reset), .ra1(ir[25:21]), .ra2(ir[20:16]), .rd1(rd1), .rd2(rd2),
        .we(state == S_WB), .wa(op == OP_R ? ir[15:11] : ir[20:16]), .wd(op == OP_LW ? mdr : alu_out)
    );
    always_comb begin
        state_n = state;
        done = 1'b0;
        case (state)
            S_IDLE:   state_n = S_FETCH;
            S_FETCH:  state_n = xfer ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            S_DECODE: state_n = is_legal(op, ir[5:0]) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                done = op == OP_BEQ || op == OP_J;
                state_n = done ? S_FETCH : op == OP_LW || op == OP_SW ? (alu_res[1:0] != 2'b00 ? S_TRAP : S_MEM) : S_WB;
            end
            S_MEM: begin
                done = xfer && op == OP_SW;
                state_n = xfer ? (op == OP_SW ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
            end
            S_WB: begin
                done = 1'b1;
                state_n = S_FETCH;
            end
            default:  state_n = S_TRAP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc <= RESET_PC;
            pc_out <= RESET_PC;
            ir <= '0;
            a <= '0;
            b <= '0;
            alu_out <= '0;
            mdr <= '0;
            wait_cnt <= '0;
            retire_q <= 1'b0;
        end else begin
            state <= state_n;
            retire_q <= done;
            wait_cnt <= mem_req && !mem_ready && state_n == state ? wait_cnt + 1'b1 : '0;
            if (state == S_FETCH && xfer) begin
                ir <= mem_rdata;
                pc_out <= pc;
                pc <= pc + 32'd4;
            end
            if (state == S_DECODE) begin
                a <= rd1;
                b <= rd2;
            end
            if (state == S_EXEC) begin
                alu_out <= alu_res;
                if (op == OP_BEQ && a == b) pc <= pc + {imm[29:0], 2'b00};
                if (op == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
            end
            if (state == S_MEM && xfer && op == OP_LW) mdr <= mem_rdata;
        end
    end
endmodule
